// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO burst reader.
// Holds the controller state encoding and the read-credit rule.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_e;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned CNT_WIDTH = 2;

  // A read may issue when the words it would add still fit once this cycle's pop retires.
  function automatic logic has_credit(input logic [CNT_WIDTH-1:0] count,
                                      input logic                 in_flight,
                                      input logic                 pop);
    logic [CNT_WIDTH:0] occ;
    occ = {1'b0, count} + {{CNT_WIDTH{1'b0}}, in_flight} - {{CNT_WIDTH{1'b0}}, pop};
    return occ < (CNT_WIDTH + 1)'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready buffer: captures one word per push and presents the oldest
// word on the stream side until it is accepted.
module stream_skid2
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  count
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  pop;

  assign m_valid = (count_q != '0);
  assign m_data  = head_q;
  assign count   = count_q;
  assign pop     = m_valid & m_ready;

  // Head always holds the oldest word; tail is only meaningful when two are held.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      case (count_q)
        CNT_WIDTH'(0): begin
          if (push) begin
            head_q  <= data_in;
            count_q <= CNT_WIDTH'(1);
          end
        end
        CNT_WIDTH'(1): begin
          if (push && pop) begin
            head_q <= data_in;
          end else if (push) begin
            tail_q  <= data_in;
            count_q <= CNT_WIDTH'(2);
          end else if (pop) begin
            count_q <= CNT_WIDTH'(0);
          end
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= data_in;
            end else begin
              count_q <= CNT_WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the synchronous FIFO: issues reads against a
// two-word credit, hides the FIFO read latency and streams the words with a last flag.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  cmd_valid,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_ready,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  rd_state_e             state_q;
  logic [LEN_WIDTH-1:0]  issue_cnt_q;
  logic [LEN_WIDTH-1:0]  out_cnt_q;
  logic                  in_flight_q;
  logic                  cmd_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic [CNT_WIDTH-1:0]  buf_count;
  logic                  pop;

  assign pop        = m_valid & m_ready;
  assign fifo_rd_en = (state_q == READ) && !fifo_empty && (issue_cnt_q != '0)
                      && has_credit(buf_count, in_flight_q, pop);
  assign m_last     = m_valid && (out_cnt_q == LEN_WIDTH'(1));
  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      in_flight_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      in_flight_q <= fifo_rd_en;
      done_q      <= 1'b0;
      if (fifo_rd_en) begin
        issue_cnt_q <= issue_cnt_q - LEN_WIDTH'(1);
      end
      if (pop) begin
        out_cnt_q <= out_cnt_q - LEN_WIDTH'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            issue_cnt_q <= cmd_len;
            out_cnt_q   <= cmd_len;
            cmd_ready_q <= 1'b0;
            if (cmd_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
              busy_q  <= 1'b1;
            end
          end
        end
        READ: begin
          // Words still in flight or buffered are delivered from DRAIN.
          if (fifo_rd_en && (issue_cnt_q == LEN_WIDTH'(1))) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (out_cnt_q == LEN_WIDTH'(1))) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  stream_skid2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .n_rst  (n_rst),
    .push   (in_flight_q),
    .data_in(fifo_dout),
    .m_ready(m_ready),
    .m_valid(m_valid),
    .m_data (m_data),
    .count  (buf_count)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural FIFO feeds the reader, and a stream
// scoreboard checks order, last flag, done timing, read credit and stall stability.
module tb_fifo_burst_reader;

  localparam int DW         = 8;
  localparam int LW         = 8;
  localparam int FIFO_DEPTH = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_ready;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .cmd_valid (cmd_valid),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  int unsigned chk_n = 0;
  int unsigned fail_n = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Behavioural FIFO: one-cycle read latency, writes dropped when full.
  logic [DW-1:0] fq[$];
  int            fcount = 0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          fifo_flush = 1'b0;
  logic          wr_acc = 1'b0;
  logic [DW-1:0] wr_acc_data = '0;

  assign fifo_empty = (fcount == 0);

  initial begin
    forever begin
      @(posedge clk);
      wr_acc <= 1'b0;
      if (fifo_flush) begin
        fq.delete();
      end else begin
        if (fifo_rd_en === 1'b1 && fq.size() != 0) fifo_dout <= fq.pop_front();
        if (wr_en && fq.size() < FIFO_DEPTH) begin
          fq.push_back(wr_data);
          wr_acc      <= 1'b1;
          wr_acc_data <= wr_data;
        end
      end
      fcount <= fq.size();
    end
  end

  // Stream scoreboard: words must appear in write order, minus those lost to reset.
  logic [DW-1:0] ref_q[$];
  int unsigned   cyc = 0, rd_cnt = 0, hs_cnt = 0, done_cnt = 0;
  int unsigned   issued = 0, delivered = 0, words_left = 0, hs_in_burst = 0;
  int unsigned   acc_cyc = 0, first_hs_cyc = 0, last_hs_cyc = 0;
  bit            model_active = 0, exp_done = 0, prev_stall = 0;
  logic [DW-1:0] prev_data = '0, last_data = '0;
  logic          prev_last = 1'b0;

  initial begin
    bit            cur_done, was_idle, next_done;
    logic [DW-1:0] exp_word;
    forever begin
      @(negedge clk);
      cyc++;
      if (fifo_flush) ref_q.delete();
      else if (wr_acc) ref_q.push_back(wr_acc_data);
      if (!n_rst) begin
        if (fifo_rd_en === 1'b1) issued++;
        for (int k = int'(delivered); k < int'(issued); k++)
          if (ref_q.size() != 0) void'(ref_q.pop_front());
        issued = 0; delivered = 0; words_left = 0;
        model_active = 0; exp_done = 0; prev_stall = 0;
      end else begin
        cur_done  = exp_done;
        was_idle  = !model_active;
        next_done = 0;
        chk("done", done, cur_done);
        chk("cmd_ready", cmd_ready, was_idle);
        chk("busy", busy, model_active && !cur_done);
        if (was_idle) chk("idle_valid", m_valid, 0);
        if (prev_stall) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, prev_data);
          chk("hold_last", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
          hs_cnt++; delivered++; last_hs_cyc = cyc;
          if (hs_in_burst == 0) first_hs_cyc = cyc;
          hs_in_burst++;
          chk("in_burst", model_active && words_left > 0, 1);
          if (ref_q.size() == 0) chk("data_avail", 0, 1);
          else begin
            exp_word = ref_q.pop_front();
            chk("data", m_data, exp_word);
          end
          chk("last", m_last, words_left == 1);
          last_data = m_data;
          if (words_left > 0) words_left--;
          if (words_left == 0 && model_active) next_done = 1;
        end
        if (fifo_rd_en) begin
          rd_cnt++; issued++;
          chk("rd_not_empty", fifo_empty, 0);
          chk("rd_credit", (issued - delivered) <= 2, 1);
        end
        if (cur_done) begin
          model_active = 0;
          done_cnt++;
        end
        if (cmd_valid && was_idle) begin
          model_active = 1;
          words_left   = cmd_len;
          acc_cyc      = cyc;
          hs_in_burst  = 0;
          if (cmd_len == 0) next_done = 1;
        end
        exp_done   = next_done;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; fifo_flush = 1'b1; cmd_valid = 1'b0; wr_en = 1'b0;
    tick(); tick();
    fifo_flush = 1'b0; n_rst = 1'b1;
    tick();
  endtask

  task automatic fifo_write(input logic [DW-1:0] v);
    wr_en = 1'b1; wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue_cmd(input logic [LW-1:0] len);
    int unsigned n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned start, input int unsigned bound, input int mode);
    for (int i = 0; i < int'(bound); i++) begin
      if (done_cnt != start) break;
      if (mode == 1) m_ready = ~m_ready;
      tick();
    end
    chk("burst_done", done_cnt - start, 1);
  endtask

  typedef struct {
    int unsigned npre;
    int unsigned len;
    int          rmode;      // 0 ready high, 1 ready toggles, 2 ready low then high
    int unsigned exp_words;
    int unsigned exp_left;
    int unsigned exp_stall_rd;
    bit          chk_lat;
  } row_t;

  row_t rows[7];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base_hs, base_rd, start;
    rows[0] = '{4, 4, 0, 4, 0, 0, 1};
    rows[1] = '{4, 3, 1, 3, 1, 0, 0};
    rows[2] = '{4, 4, 2, 4, 0, 2, 0};
    rows[3] = '{3, 1, 1, 1, 2, 0, 0};
    rows[4] = '{2, 2, 2, 2, 0, 2, 0};
    rows[5] = '{4, 2, 0, 2, 2, 0, 1};
    rows[6] = '{1, 1, 2, 1, 0, 1, 0};

    do_reset();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    foreach (rows[r]) begin
      do_reset();
      for (int v = 1; v <= int'(rows[r].npre); v++) fifo_write(DW'(v));
      m_ready = (rows[r].rmode != 2);
      base_hs = hs_cnt; base_rd = rd_cnt; start = done_cnt;
      issue_cmd(LW'(rows[r].len));
      if (rows[r].rmode == 2) begin
        repeat (8) tick();
        chk("stall_rd", rd_cnt - base_rd, rows[r].exp_stall_rd);
        m_ready = 1'b1;
      end
      wait_done(start, 100, rows[r].rmode);
      m_ready = 1'b1;
      chk("words", hs_cnt - base_hs, rows[r].exp_words);
      chk("fifo_left", fcount, rows[r].exp_left);
      if (rows[r].chk_lat) begin
        chk("first_latency", first_hs_cyc - acc_cyc, 3);
        chk("back_to_back", last_hs_cyc - first_hs_cyc, rows[r].len - 1);
      end
    end

    // FIFO starts empty; words trickle in.
    do_reset();
    m_ready = 1'b1;
    base_hs = hs_cnt; base_rd = rd_cnt; start = done_cnt;
    issue_cmd(2);
    repeat (3) tick();
    chk("empty_no_rd", rd_cnt - base_rd, 0);
    fifo_write(7);
    repeat (4) tick();
    fifo_write(9);
    wait_done(start, 30, 0);
    chk("trickle_words", hs_cnt - base_hs, 2);
    chk("trickle_last", last_data, 9);

    // Zero-length burst.
    base_hs = hs_cnt; base_rd = rd_cnt; start = done_cnt;
    issue_cmd(0);
    repeat (3) tick();
    chk("zero_done", done_cnt - start, 1);
    chk("zero_rd", rd_cnt - base_rd, 0);
    chk("zero_words", hs_cnt - base_hs, 0);
    chk("zero_ready", cmd_ready, 1);

    // Reset while a word is presented.
    do_reset();
    for (int v = 1; v <= 4; v++) fifo_write(DW'(v));
    m_ready = 1'b0;
    issue_cmd(4);
    for (int i = 0; i < 10 && !m_valid; i++) tick();
    chk("pre_rst_valid", m_valid, 1);
    repeat (2) tick();
    n_rst = 1'b0;
    tick();
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rd_en", fifo_rd_en, 0);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_m_data", m_data, 0);
    chk("abort_m_last", m_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    n_rst = 1'b1;
    m_ready = 1'b1;
    start = done_cnt;
    issue_cmd(1);
    wait_done(start, 30, 0);
    chk("after_abort_word", last_data, 3);
    chk("after_abort_left", fcount, 1);

    // Random bursts with random writes, back-pressure and ignored commands.
    for (int b = 0; b < 25; b++) begin
      int unsigned len;
      len = $urandom_range(0, 6);
      start = done_cnt;
      issue_cmd(LW'(len));
      for (int i = 0; i < 300; i++) begin
        if (done_cnt != start) break;
        m_ready   = ($urandom_range(0, 3) != 0);
        wr_en     = (fcount < FIFO_DEPTH) && ($urandom_range(0, 1) == 1);
        wr_data   = DW'($urandom_range(0, 255));
        cmd_valid = ($urandom_range(0, 3) == 0);
        cmd_len   = LW'($urandom_range(0, 255));
        tick();
      end
      wr_en = 1'b0; cmd_valid = 1'b0;
      chk("rand_done", done_cnt - start, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", chk_n, fail_n);
    $finish;
  end

endmodule
